// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: bus field widths,
// FSM state encoding, default timeout data word and the round-robin pick rule.
package mem_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Two-way round-robin choice: a lone requester wins outright, on a tie the
    // master that did not win last time is chosen.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        logic pick;
        pick = 1'b0;
        if (req == 2'b10) begin
            pick = 1'b1;
        end else if (req == 2'b11) begin
            pick = ~last_grant;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational pick from the request pair and the
// remembered last winner, which is only updated when the caller commits a grant.
module mem_arbiter_rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt_idx
);

    logic last_grant_q;
    logic last_grant_d;

    // Pick the winner for this cycle
    always_comb begin
        gnt_idx = rr_pick(req, last_grant_q);
    end

    // Remember the winner only when the grant is actually taken
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_en) begin
            last_grant_d = gnt_idx;
        end
    end

    // last_grant resets to master 1 so master 0 wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory/peripheral bus port between the instruction-fetch master (0)
// and the load/store master (1). One transaction is in flight at a time; a
// timeout converts a hung slave into an error response so a master never
// waits forever.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int                AW       = 32,
    parameter int                TIMEOUT  = 256,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_valid,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_valid,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              s_valid,
    output logic [AW-1:0]     s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata
);

    // Counter only needs to reach TIMEOUT-1; a TIMEOUT of 0 disables the check.
    localparam int              CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              TIMEOUT_EN = (TIMEOUT > 0);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;

    logic              s_valid_q, s_valid_d;
    logic [AW-1:0]     s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [STRB_W-1:0] s_wstrb_q, s_wstrb_d;

    logic [1:0]        m_ready_q, m_ready_d;
    logic [1:0]        m_err_q, m_err_d;
    logic [DATA_W-1:0] m_rdata_q [2];
    logic [DATA_W-1:0] m_rdata_d [2];

    logic [1:0]        m_valid;
    logic              pick_idx;
    logic              grant_en;
    logic              timeout_hit;
    logic              cpl_fire;
    logic              cpl_err;

    assign m_valid = {m1_valid, m0_valid};

    mem_arbiter_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .req      (m_valid),
        .grant_en (grant_en),
        .gnt_idx  (pick_idx)
    );

    // The counter has been running since issue; TIMEOUT-1 is the last cycle allowed.
    always_comb begin
        timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);
    end

    // Next-state logic: grant in IDLE, hold the request in REQ, wait in RESP
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        s_valid_d = s_valid_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_wstrb_d = s_wstrb_q;
        grant_en  = 1'b0;
        cpl_fire  = 1'b0;
        cpl_err   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A ready pulse in flight means the completed master may still
                // be holding valid for the old request, so skip this cycle.
                if (!(|m_ready_q) && (|m_valid)) begin
                    grant_en  = 1'b1;
                    gnt_d     = pick_idx;
                    s_valid_d = 1'b1;
                    s_addr_d  = pick_idx ? m1_addr  : m0_addr;
                    s_wdata_d = pick_idx ? m1_wdata : m0_wdata;
                    s_wstrb_d = pick_idx ? m1_wstrb : m0_wstrb;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (s_ready && s_rvalid) begin
                    cpl_fire = 1'b1;
                end else if (timeout_hit) begin
                    cpl_fire = 1'b1;
                    cpl_err  = 1'b1;
                end else if (s_ready) begin
                    s_valid_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (s_rvalid) begin
                    cpl_fire = 1'b1;
                end else if (timeout_hit) begin
                    cpl_fire = 1'b1;
                    cpl_err  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cpl_fire) begin
            s_valid_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
        end
    end

    // Route a completion to the granted master only; the other keeps its old data
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_ready_d[i] = 1'b0;
            m_err_d[i]   = m_err_q[i];
            m_rdata_d[i] = m_rdata_q[i];
            if (cpl_fire && (int'(gnt_q) == i)) begin
                m_ready_d[i] = 1'b1;
                m_err_d[i]   = cpl_err;
                m_rdata_d[i] = cpl_err ? ERR_DATA : s_rdata;
            end
        end
    end

    // Arbiter state and slave-side request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            gnt_q     <= 1'b0;
            s_valid_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wstrb_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            s_valid_q <= s_valid_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            s_wstrb_q <= s_wstrb_d;
        end
    end

    // Master-side response registers; rdata/err hold until that master's next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            m_ready_q    <= '0;
            m_err_q      <= '0;
            m_rdata_q[0] <= '0;
            m_rdata_q[1] <= '0;
        end else begin
            m_ready_q    <= m_ready_d;
            m_err_q      <= m_err_d;
            m_rdata_q[0] <= m_rdata_d[0];
            m_rdata_q[1] <= m_rdata_d[1];
        end
    end

    assign s_valid  = s_valid_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;

    assign m0_ready = m_ready_q[0];
    assign m0_err   = m_err_q[0];
    assign m0_rdata = m_rdata_q[0];
    assign m1_ready = m_ready_q[1];
    assign m1_err   = m_err_q[1];
    assign m1_rdata = m_rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a directed reset-during-response case followed by
// randomized two-master traffic against a randomized slave (stalls, hangs,
// spurious responses). Expected responses are queued when the slave decides
// how to answer; an independent monitor checks grants, request fields,
// response data/err/latency and output holding.
module tb_mem_arbiter;

    localparam int          N_TXN       = 40;
    localparam int          TMO         = 16;
    localparam logic [31:0] ERR_WORD    = 32'hDEADBEEF;
    localparam int          CYCLE_LIMIT = 20000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        chk_data;
        logic [7:0]  lat;
    } rsp_t;

    typedef enum logic [1:0] {SL_NORMAL, SL_HANG_REQ, SL_HANG_RESP} sl_mode_e;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic [1:0]  mv;
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0]  ms [2];

    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  mr, me;
    logic [31:0] mrd [2];

    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready, s_rvalid;
    logic [31:0] s_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt [2];

    rsp_t exp_q0 [$];
    rsp_t exp_q1 [$];

    assign mr     = {m1_ready, m0_ready};
    assign me     = {m1_err, m0_err};
    assign mrd[0] = m0_rdata;
    assign mrd[1] = m1_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW       (32),
        .TIMEOUT  (TMO),
        .ERR_DATA (ERR_WORD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_valid (mv[0]),
        .m0_addr  (ma[0]),
        .m0_wdata (mw[0]),
        .m0_wstrb (ms[0]),
        .m0_ready (m0_ready),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_valid (mv[1]),
        .m1_addr  (ma[1]),
        .m1_wdata (mw[1]),
        .m1_wstrb (ms[1]),
        .m1_ready (m1_ready),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .s_valid  (s_valid),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_ready  (s_ready),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    logic        last_g   = 1'b1;
    logic        sv_prev  = 1'b0;
    logic        eg;
    int          rise_cyc = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic [31:0] hold_rd [2];
    logic [1:0]  hold_err = 2'b00;
    rsp_t        e;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            check("rst_ctrl", {m1_ready, m0_ready, m1_err, m0_err, s_valid, s_wstrb}, 64'd0);
            check("rst_saddr_wdata", {s_addr, s_wdata}, 64'd0);
            check("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
            last_g     = 1'b1;
            sv_prev    = 1'b0;
            exp_q0.delete();
            exp_q1.delete();
            hold_rd[0] = 32'd0;
            hold_rd[1] = 32'd0;
            hold_err   = 2'b00;
        end else begin
            if (s_valid && !sv_prev) begin
                if (mv == 2'b00) begin
                    total++;
                    bad++;
                    $display("FAIL grant_without_request: s_valid=1 with no master valid (cycle %0d)", cyc);
                end else begin
                    // Round-robin rule: lone requester wins, a tie goes to the non-last winner
                    if (mv == 2'b01)      eg = 1'b0;
                    else if (mv == 2'b10) eg = 1'b1;
                    else                  eg = ~last_g;
                    check("grant_owner", s_addr[31], eg);
                    check("req_addr", s_addr, ma[eg]);
                    check("req_wdata", s_wdata, mw[eg]);
                    check("req_wstrb", s_wstrb, ms[eg]);
                    last_g = eg;
                end
                cap_addr  = s_addr;
                cap_wdata = s_wdata;
                cap_wstrb = s_wstrb;
                rise_cyc  = cyc;
            end else if (s_valid) begin
                check("req_stable", {s_addr, s_wdata}, {cap_addr, cap_wdata});
                check("req_stable_strb", s_wstrb, cap_wstrb);
            end

            if (m0_ready && m1_ready) begin
                total++;
                bad++;
                $display("FAIL both_ready: m0_ready=1 m1_ready=1 required at most one (cycle %0d)", cyc);
            end

            for (int i = 0; i < 2; i++) begin
                if (mr[i]) begin
                    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ready: m%0d_ready=1 required 0 (cycle %0d)", i, cyc);
                    end else begin
                        if (i == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        check("rsp_err", me[i], e.err);
                        if (e.chk_data) check("rsp_data", mrd[i], e.data);
                        check("rsp_latency", cyc - rise_cyc, e.lat);
                        done_cnt[i]++;
                    end
                    hold_rd[i]  = mrd[i];
                    hold_err[i] = me[i];
                end else begin
                    check("rsp_hold", {me[i], mrd[i]}, {hold_err[i], hold_rd[i]});
                end
            end
            sv_prev = s_valid;
        end
    end

    // ---------------- stimulus ----------------
    int          sph;
    sl_mode_e    smode;
    int          sd, srd;
    logic [31:0] sdata;
    int          gap [2];
    int          issued [2];
    int          k;

    task automatic master_step();
        for (int i = 0; i < 2; i++) begin
            if (mv[i] && mr[i]) begin
                mv[i]  = 1'b0;
                gap[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            end
            if (!mv[i] && issued[i] < N_TXN) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else begin
                    ma[i] = {i[0], 13'(issued[i]), 16'($urandom), 2'b00};
                    mw[i] = $urandom;
                    ms[i] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                    mv[i] = 1'b1;
                    issued[i]++;
                end
            end
        end
    endtask

    task automatic slave_step();
        rsp_t r;
        int   m;
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = $urandom;
        if (mr != 2'b00) sph = 0;
        if (sph == 0) begin
            if (s_valid) begin
                m     = int'($urandom_range(0, 7));
                sd    = int'($urandom_range(0, 3));
                srd   = int'($urandom_range(0, 3));
                sdata = $urandom;
                if (m == 0)      smode = SL_HANG_REQ;
                else if (m == 1) smode = SL_HANG_RESP;
                else             smode = SL_NORMAL;
                r.chk_data = (ms[s_addr[31]] == 4'd0);
                if (smode == SL_NORMAL) begin
                    r.data = sdata;
                    r.err  = 1'b0;
                    r.lat  = 8'(sd + srd + 1);
                end else begin
                    r.data = ERR_WORD;
                    r.err  = 1'b1;
                    r.lat  = 8'(TMO);
                end
                if (s_addr[31]) exp_q1.push_back(r);
                else            exp_q0.push_back(r);
                sph = 1;
            end else if ($urandom_range(0, 5) == 0) begin
                s_rvalid = 1'b1;  // stray response while the bus is idle
            end
        end
        if (sph == 1) begin
            if (smode != SL_HANG_REQ) begin
                if (sd == 0) begin
                    s_ready = 1'b1;
                    if (smode == SL_NORMAL && srd == 0) begin
                        s_rvalid = 1'b1;
                        s_rdata  = sdata;
                        sph      = 3;
                    end else begin
                        sph = 2;
                    end
                end else begin
                    sd--;
                end
            end
        end else if (sph == 2) begin
            if (smode == SL_NORMAL) begin
                srd--;
                if (srd == 0) begin
                    s_rvalid = 1'b1;
                    s_rdata  = sdata;
                    sph      = 3;
                end
            end
        end
    endtask

    initial begin
        mv = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ma[i] = 32'd0; mw[i] = 32'd0; ms[i] = 4'd0;
            gap[i] = 0; issued[i] = 0; done_cnt[i] = 0;
            hold_rd[i] = 32'd0;
        end
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'd0;
        sph = 0; smode = SL_NORMAL; sd = 0; srd = 0; sdata = 32'd0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Directed: m0 read of 0x10, slave accepts, reset arrives while awaiting the response
        mv[0] = 1'b1; ma[0] = 32'h10; mw[0] = 32'd0; ms[0] = 4'd0;
        k = 0;
        while (!s_valid && k < 10) begin
            @(negedge clk); #1;
            k++;
        end
        if (!s_valid) begin
            total++;
            bad++;
            $display("FAIL directed_issue: s_valid=0 required 1 within 10 cycles");
        end
        s_ready = 1'b1;
        @(negedge clk); #1;
        s_ready = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        mv[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_abandon_m0", done_cnt[0], 0);

        // Random traffic; both masters start together so the first tie after reset is exercised
        while ((issued[0] < N_TXN || issued[1] < N_TXN || mv != 2'b00) && cyc < CYCLE_LIMIT) begin
            master_step();
            slave_step();
            @(negedge clk); #1;
        end
        s_ready = 1'b0; s_rvalid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        if (cyc >= CYCLE_LIMIT) begin
            total++;
            bad++;
            $display("FAIL cycle_budget: reached %0d cycles required completion earlier", cyc);
        end
        check("done_m0", done_cnt[0], N_TXN);
        check("done_m1", done_cnt[1], N_TXN);
        check("pending_exp", exp_q0.size() + exp_q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
